// File: rtl/antic_dma_responder.sv
`default_nettype none
// ============================================================================
//  Module      : antic_dma_responder
//  Description : Memory-side responder for ANTIC display-list / playfield DMA.
//                Steals the bus from the 6502 by dropping RDY while halt_L is
//                low, drives ANTIC's address to RAM and returns read bytes on
//                DB_out with a one-clock db_valid strobe.
//  Options     : DMA_STEAL_COUNT_EN - adds steal_count / steal_clr ports and
//                a 16-bit counter of stolen CPU clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module antic_dma_responder #(
    parameter int MEM_LAT         = 1,   // RAM read latency, 1..3 clocks
    parameter int MAX_WRITE_DEFER = 3    // grant deferral limit during writes, 1..7
) (
    input  logic        phi2,
    input  logic        rst_L,
    input  logic        halt_L,
    input  logic [15:0] antic_addr,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_RW,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  mem_rdata,
`ifdef DMA_STEAL_COUNT_EN
    input  logic        steal_clr,
    output logic [15:0] steal_count,
`endif
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        RDY,
    output logic [7:0]  DB_out,
    output logic        db_valid,
    output logic [7:0]  cpu_din,
    output logic        dma_active
);

    localparam logic [1:0] ST_CPU     = 2'b00;
    localparam logic [1:0] ST_DEFER   = 2'b01;
    localparam logic [1:0] ST_DMA     = 2'b10;
    localparam logic [1:0] ST_RELEASE = 2'b11;

    localparam logic [3:0] DEFER_MAX  = 4'(MAX_WRITE_DEFER);

    logic [1:0]         state_q, state_d;
    logic [2:0]         defer_cnt_q, defer_cnt_d;
    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [7:0]         db_out_q, db_out_d;
    logic               read_issue;
    logic               defer_force;

    // One ANTIC read per DMA clock while the request is still held.
    assign read_issue  = (state_q == ST_DMA) && !halt_L;

    // The counter holds the number of write cycles already seen with halt
    // pending; the grant is forced on the clock where this write reaches it.
    assign defer_force = ({1'b0, defer_cnt_q} + 4'd1) >= DEFER_MAX;

    // State register.
    always_ff @(posedge phi2 or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= ST_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: CPU -> (DEFER) -> DMA -> RELEASE -> CPU.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CPU: begin
                if (!halt_L) begin
                    state_d = cpu_RW ? ST_DMA : ST_DEFER;
                end
            end
            ST_DEFER: begin
                if (halt_L) begin
                    state_d = ST_CPU;
                end else if (cpu_RW || defer_force) begin
                    state_d = ST_DMA;
                end
            end
            ST_DMA: begin
                if (halt_L) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // CPU is still halted, so a renewed request skips deferral.
                if (!halt_L) begin
                    state_d = ST_DMA;
                end else if (vld_d == '0) begin
                    state_d = ST_CPU;
                end
            end
            default: state_d = ST_CPU;
        endcase
    end

    // Output decode: bus mux, write enable and CPU stall per state.
    always_comb begin
        mem_addr   = cpu_addr;
        mem_we     = 1'b0;
        RDY        = 1'b0;
        dma_active = 1'b0;
        case (state_q)
            ST_CPU: begin
                mem_we = ~cpu_RW;
                RDY    = 1'b1;
            end
            ST_DEFER: begin
                // The 6502 ignores RDY on writes, so let them complete.
                mem_we = ~cpu_RW;
            end
            ST_DMA, ST_RELEASE: begin
                mem_addr   = antic_addr;
                dma_active = 1'b1;
            end
            default: begin
                mem_addr = cpu_addr;
            end
        endcase
    end

    // Defer counter: seeded on the first deferred write, saturates at 7.
    always_comb begin
        defer_cnt_d = 3'd0;
        if ((state_q == ST_CPU) && !halt_L && !cpu_RW) begin
            defer_cnt_d = 3'd1;
        end else if (state_q == ST_DEFER) begin
            defer_cnt_d = (defer_cnt_q == 3'd7) ? defer_cnt_q : (defer_cnt_q + 3'd1);
        end
    end

    // Read-valid pipeline; the last stage is the db_valid strobe and the
    // byte is captured as its valid bit enters that stage.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = read_issue;
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        db_out_d = vld_d[MEM_LAT-1] ? mem_rdata : db_out_q;
    end

    // Datapath registers; reset discards any read still in flight.
    always_ff @(posedge phi2 or negedge rst_L) begin
        if (!rst_L) begin
            defer_cnt_q <= 3'd0;
            vld_q       <= '0;
            db_out_q    <= 8'h00;
        end else begin
            defer_cnt_q <= defer_cnt_d;
            vld_q       <= vld_d;
            db_out_q    <= db_out_d;
        end
    end

    assign DB_out    = db_out_q;
    assign db_valid  = vld_q[MEM_LAT-1];
    assign mem_wdata = cpu_dout;
    assign cpu_din   = mem_rdata;

`ifdef DMA_STEAL_COUNT_EN
    logic [15:0] steal_count_q, steal_count_d;

    // Stolen-cycle counter; a clear wins over a same-clock increment.
    always_comb begin
        steal_count_d = steal_count_q;
        if (steal_clr) begin
            steal_count_d = 16'h0000;
        end else if (read_issue) begin
            steal_count_d = steal_count_q + 16'h0001;
        end
    end

    // Stolen-cycle counter register.
    always_ff @(posedge phi2 or negedge rst_L) begin
        if (!rst_L) begin
            steal_count_q <= 16'h0000;
        end else begin
            steal_count_q <= steal_count_d;
        end
    end

    assign steal_count = steal_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_antic_dma_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_antic_dma_responder
//  Description : Self-checking bench for antic_dma_responder. Two instances:
//                MEM_LAT=1 (table-driven) and MEM_LAT=3 (hand sequence).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_antic_dma_responder;

    logic        phi2 = 1'b0;
    logic        rst_L;
    logic        halt_L;
    logic [15:0] antic_addr;
    logic [15:0] cpu_addr;
    logic        cpu_RW;
    logic [7:0]  cpu_dout;

    logic [15:0] mem_addr1, mem_addr3;
    logic [7:0]  mem_wdata1, mem_wdata3;
    logic        mem_we1, mem_we3;
    logic        RDY1, RDY3;
    logic [7:0]  DB_out1, DB_out3;
    logic        db_valid1, db_valid3;
    logic [7:0]  cpu_din1, cpu_din3;
    logic        dma_active1, dma_active3;
    logic [7:0]  mem_rdata1, mem_rdata3;
    logic [15:0] a3_d1, a3_d2;
`ifdef DMA_STEAL_COUNT_EN
    logic        steal_clr;
    logic [15:0] steal_count1, steal_count3;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 phi2 = ~phi2;

    // RAM contents as a pure function of address.
    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0] * 8'd13;
        return (a == 16'h3000) ? 8'hA5 : (lo ^ 8'h6B);
    endfunction

    // Latency-1 RAM: data for the current address is sampled at the next edge.
    assign mem_rdata1 = ram_rd(mem_addr1);

    // Latency-3 RAM: data reflects the address presented two clocks earlier.
    always @(posedge phi2) begin
        a3_d1 <= mem_addr3;
        a3_d2 <= a3_d1;
    end
    assign mem_rdata3 = ram_rd(a3_d2);

    antic_dma_responder #(.MEM_LAT(1), .MAX_WRITE_DEFER(3)) u_dut1 (
        .phi2       (phi2),
        .rst_L      (rst_L),
        .halt_L     (halt_L),
        .antic_addr (antic_addr),
        .cpu_addr   (cpu_addr),
        .cpu_RW     (cpu_RW),
        .cpu_dout   (cpu_dout),
        .mem_rdata  (mem_rdata1),
`ifdef DMA_STEAL_COUNT_EN
        .steal_clr  (steal_clr),
        .steal_count(steal_count1),
`endif
        .mem_addr   (mem_addr1),
        .mem_wdata  (mem_wdata1),
        .mem_we     (mem_we1),
        .RDY        (RDY1),
        .DB_out     (DB_out1),
        .db_valid   (db_valid1),
        .cpu_din    (cpu_din1),
        .dma_active (dma_active1)
    );

    antic_dma_responder #(.MEM_LAT(3), .MAX_WRITE_DEFER(3)) u_dut3 (
        .phi2       (phi2),
        .rst_L      (rst_L),
        .halt_L     (halt_L),
        .antic_addr (antic_addr),
        .cpu_addr   (cpu_addr),
        .cpu_RW     (cpu_RW),
        .cpu_dout   (cpu_dout),
        .mem_rdata  (mem_rdata3),
`ifdef DMA_STEAL_COUNT_EN
        .steal_clr  (steal_clr),
        .steal_count(steal_count3),
`endif
        .mem_addr   (mem_addr3),
        .mem_wdata  (mem_wdata3),
        .mem_we     (mem_we3),
        .RDY        (RDY3),
        .DB_out     (DB_out3),
        .db_valid   (db_valid3),
        .cpu_din    (cpu_din3),
        .dma_active (dma_active3)
    );

    typedef struct {
        logic        halt_L;
        logic        cpu_RW;
        logic [15:0] cpu_addr;
        logic [15:0] antic_addr;
        logic        exp_rdy;
        logic        exp_we;
        logic        exp_sel_antic;
        logic        exp_issue;
        logic        exp_act;
    } vec_t;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // f = {halt_L, cpu_RW, exp_rdy, exp_we, exp_sel_antic, exp_issue, exp_act}
    function automatic void add(input logic [6:0] f, input logic [15:0] ca, input logic [15:0] aa);
        vec_t v;
        v.halt_L        = f[6];
        v.cpu_RW        = f[5];
        v.exp_rdy       = f[4];
        v.exp_we        = f[3];
        v.exp_sel_antic = f[2];
        v.exp_issue     = f[1];
        v.exp_act       = f[0];
        v.cpu_addr      = ca;
        v.antic_addr    = aa;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0]  exp_db;
        logic [15:0] exp_addr;
        logic [5:0]  h_seq, rdy_seq, dbv_seq, act_seq;

        // ---------------- vector table (MEM_LAT = 1 instance) ----------------
        add(7'b11_10_000, 16'h1000, 16'h3FFF);  // idle CPU read
        add(7'b01_10_000, 16'h1001, 16'h3000);  // halt during CPU read
        add(7'b01_00_111, 16'h1002, 16'h3000);  // DMA read 3000
        add(7'b11_00_101, 16'h1003, 16'h3FFF);  // halt released, strobe A5
        add(7'b11_00_101, 16'h1004, 16'h3FFF);  // RELEASE
        add(7'b00_11_000, 16'h2000, 16'h3FFF);  // write 1, halt pending
        add(7'b00_01_000, 16'h2001, 16'h3FFF);  // write 2 in DEFER
        add(7'b00_01_000, 16'h2002, 16'h3FFF);  // write 3, grant forced
        add(7'b00_00_111, 16'h2003, 16'h3001);  // DMA read 3001
        add(7'b11_00_101, 16'h1005, 16'h3FFF);
        add(7'b11_00_101, 16'h1006, 16'h3FFF);
        add(7'b00_11_000, 16'h2100, 16'h3FFF);  // write, halt pending
        add(7'b10_01_000, 16'h2101, 16'h3FFF);  // halt withdrawn in DEFER
        add(7'b11_10_000, 16'h1007, 16'h3FFF);  // back in CPU, no DMA
        add(7'b00_11_000, 16'h2102, 16'h3FFF);  // write, halt pending
        add(7'b01_00_000, 16'h2200, 16'h3FFF);  // read ends deferral
        add(7'b01_00_111, 16'h1008, 16'h3000);  // burst of four reads
        add(7'b01_00_111, 16'h1008, 16'h3001);
        add(7'b01_00_111, 16'h1008, 16'h3002);
        add(7'b01_00_111, 16'h1008, 16'h3003);
        add(7'b11_00_101, 16'h1009, 16'h3FFF);
        add(7'b11_00_101, 16'h100A, 16'h3FFF);  // RELEASE
        add(7'b01_10_000, 16'h100B, 16'h3FFF);  // CPU, RDY high
        add(7'b01_00_111, 16'h100C, 16'h3010);
        add(7'b11_00_101, 16'h100D, 16'h3FFF);
        add(7'b01_00_101, 16'h100E, 16'h3FFF);  // RELEASE, halt again
        add(7'b01_00_111, 16'h100F, 16'h3011);  // straight back to DMA
        add(7'b11_00_101, 16'h1010, 16'h3FFF);
        add(7'b11_00_101, 16'h1011, 16'h3FFF);
        for (int i = 0; i < 6; i++) begin
            add(7'b11_10_000, 16'h1012 + 16'(i), 16'h3FFF);
        end

        // ---------------- reset ----------------
        rst_L      = 1'b0;
        halt_L     = 1'b1;
        cpu_RW     = 1'b1;
        cpu_addr   = 16'h0000;
        antic_addr = 16'h0000;
        cpu_dout   = 8'h00;
`ifdef DMA_STEAL_COUNT_EN
        steal_clr  = 1'b0;
`endif
        repeat (2) @(posedge phi2);
        @(negedge phi2);
        chk("rst_rdy1", 0, RDY1, 1);
        chk("rst_dbv1", 0, db_valid1, 0);
        chk("rst_db1", 0, DB_out1, 8'h00);
        chk("rst_act1", 0, dma_active1, 0);
        chk("rst_rdy3", 0, RDY3, 1);
        chk("rst_dbv3", 0, db_valid3, 0);
        chk("rst_db3", 0, DB_out3, 8'h00);
        chk("rst_act3", 0, dma_active3, 0);
`ifdef DMA_STEAL_COUNT_EN
        chk("rst_steal", 0, steal_count1, 0);
`endif
        @(posedge phi2);
        #1;
        rst_L = 1'b1;

        // ---------------- table run with scoreboard ----------------
        exp_db = 8'h00;
        for (int k = 0; k < vecs.size(); k++) begin
            halt_L     = vecs[k].halt_L;
            cpu_RW     = vecs[k].cpu_RW;
            cpu_addr   = vecs[k].cpu_addr;
            antic_addr = vecs[k].antic_addr;
            cpu_dout   = vecs[k].cpu_addr[7:0] ^ 8'h3C;
            if (vecs[k].exp_issue) begin
                sb.push_back('{k + 1, ram_rd(vecs[k].antic_addr)});
            end
            @(negedge phi2);
            exp_addr = vecs[k].exp_sel_antic ? vecs[k].antic_addr : vecs[k].cpu_addr;
            chk("rdy", k, RDY1, vecs[k].exp_rdy);
            chk("mem_we", k, mem_we1, vecs[k].exp_we);
            chk("mem_addr", k, mem_addr1, exp_addr);
            chk("dma_active", k, dma_active1, vecs[k].exp_act);
            chk("mem_wdata", k, mem_wdata1, vecs[k].cpu_addr[7:0] ^ 8'h3C);
            chk("cpu_din", k, cpu_din1, ram_rd(exp_addr));
            if (sb.size() > 0 && sb[0].due == k) begin
                chk("db_valid", k, db_valid1, 1);
                chk("db_out", k, DB_out1, sb[0].data);
                exp_db = sb[0].data;
                void'(sb.pop_front());
            end else begin
                chk("db_valid", k, db_valid1, 0);
                chk("db_hold", k, DB_out1, exp_db);
            end
            @(posedge phi2);
            #1;
        end
        chk("sb_empty", 0, sb.size(), 0);
        chk("idle_rdy3", 0, RDY3, 1);

        // ---------------- MEM_LAT = 3, one-clock halt ----------------
        h_seq   = 6'b111100;
        rdy_seq = 6'b100001;
        dbv_seq = 6'b010000;
        act_seq = 6'b011110;
        cpu_RW  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            halt_L     = h_seq[c];
            antic_addr = (c == 1) ? 16'h3000 : 16'h3333;
            @(negedge phi2);
            chk("lat3_rdy", c, RDY3, rdy_seq[c]);
            chk("lat3_dbv", c, db_valid3, dbv_seq[c]);
            chk("lat3_act", c, dma_active3, act_seq[c]);
            if (dbv_seq[c]) begin
                chk("lat3_db", c, DB_out3, 8'hA5);
            end
            @(posedge phi2);
            #1;
        end

        // ---------------- asynchronous reset mid-DMA ----------------
        halt_L     = 1'b0;
        antic_addr = 16'h3002;
        @(posedge phi2);      // CPU -> DMA
        #1;
        @(posedge phi2);      // first DMA read issued
        #1;
        chk("pre_rst_dbv1", 0, db_valid1, 1);
        chk("pre_rst_db1", 0, DB_out1, 8'h71);
        rst_L = 1'b0;
        #1;
        chk("arst_rdy1", 0, RDY1, 1);
        chk("arst_dbv1", 0, db_valid1, 0);
        chk("arst_db1", 0, DB_out1, 8'h00);
        chk("arst_act1", 0, dma_active1, 0);
        chk("arst_rdy3", 0, RDY3, 1);
        chk("arst_dbv3", 0, db_valid3, 0);
        @(posedge phi2);
        #1;
        halt_L = 1'b1;
        rst_L  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge phi2);
            chk("post_rst_dbv1", c, db_valid1, 0);
            chk("post_rst_dbv3", c, db_valid3, 0);
            chk("post_rst_rdy3", c, RDY3, 1);
            chk("post_rst_db3", c, DB_out3, 8'h00);
        end

`ifdef DMA_STEAL_COUNT_EN
        // ---------------- stolen-cycle counter ----------------
        @(posedge phi2);
        #1;
        halt_L = 1'b0;        // CPU clock, then five DMA clocks
        repeat (6) @(posedge phi2);
        #1;
        halt_L = 1'b1;
        @(negedge phi2);
        chk("steal5_1", 0, steal_count1, 16'd5);
        chk("steal5_3", 0, steal_count3, 16'd5);
        repeat (6) @(posedge phi2);
        #1;
        halt_L = 1'b0;        // CPU clock
        @(posedge phi2);
        #1;
        steal_clr = 1'b1;     // DMA clock with clear
        @(posedge phi2);
        #1;
        steal_clr = 1'b0;
        @(negedge phi2);
        chk("steal_clr", 0, steal_count1, 16'd0);
        @(negedge phi2);
        chk("steal_after", 0, steal_count1, 16'd1);
        @(posedge phi2);
        #1;
        halt_L = 1'b1;
        repeat (6) @(posedge phi2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
